// File: rtl/spi_flash_slave.sv
// rtl/spi_flash_slave.sv - SPI-flash responder (mode 0, oversampled) with byte-wide memory port
// Optional fast read (0x0B) under SPI_FLASH_SLAVE_FAST_READ_EN.
module spi_flash_slave #(
    parameter logic [23:0] JEDEC_ID  = 24'hEF4018,
    parameter int          PAGE_BITS = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_spi_cs,
    input  logic        i_spi_dclk,
    input  logic        i_spi_mosi,
    output logic        o_spi_miso,
    output logic [23:0] o_mem_addr,
    output logic        o_mem_rd_req,
    input  logic [7:0]  i_mem_rd_data,
    output logic        o_mem_wr_en,
    output logic [7:0]  o_mem_wr_data,
    input  logic        i_busy,
    output logic        o_wel,
    output logic [7:0]  o_cmd,
    output logic        o_cmd_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_OPCODE,
        S_ADDR,
        S_RD_DATA,
        S_WR_DATA,
        S_STATUS,
        S_ID,
        S_IGNORE
    } state_t;

    localparam logic [PAGE_BITS-1:0] PAGE_ONE = {{(PAGE_BITS-1){1'b0}}, 1'b1};

    state_t      state;
    state_t      state_nx;

    logic [1:0]  cs_sync;
    logic [1:0]  dclk_sync;
    logic [1:0]  mosi_sync;
    logic        cs_d;
    logic        dclk_d;
    logic        cs_s;
    logic        dclk_s;
    logic        mosi_s;
    logic        cs_fall;
    logic        cs_rise;
    logic        active;
    logic        rise;
    logic        fall;
    logic        byte_done;

    logic [2:0]  bit_cnt;
    logic [2:0]  byte_cnt;
    logic [6:0]  rx_sr;
    logic [7:0]  rx_byte;
    logic [7:0]  tx_sr;
    logic [7:0]  load_byte;
    logic [7:0]  rd_buf;
    logic        rd_pend;
    logic [1:0]  id_idx;
    logic        is_read;
    logic        fast;
    logic [2:0]  addr_last;
    logic        wr_allow;
    logic        wrote;
    logic        cmd_decoded;
    logic        dec_read;
    logic        dec_fast;

    // Synchronisers reset low on cs so a reset released mid-transaction
    // (cs already low) waits for a genuine cs fall before doing anything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_sync   <= 2'b00;
            dclk_sync <= 2'b00;
            mosi_sync <= 2'b00;
            cs_d      <= 1'b0;
            dclk_d    <= 1'b0;
        end else begin
            cs_sync   <= {cs_sync[0], i_spi_cs};
            dclk_sync <= {dclk_sync[0], i_spi_dclk};
            mosi_sync <= {mosi_sync[0], i_spi_mosi};
            cs_d      <= cs_sync[1];
            dclk_d    <= dclk_sync[1];
        end
    end

    assign cs_s      = cs_sync[1];
    assign dclk_s    = dclk_sync[1];
    assign mosi_s    = mosi_sync[1];
    assign cs_fall   = cs_d & ~cs_s;
    assign cs_rise   = ~cs_d & cs_s;
    assign active    = ~cs_s && (state != S_IDLE);
    assign rise      = active & dclk_s & ~dclk_d;
    assign fall      = active & ~dclk_s & dclk_d;
    assign byte_done = rise && (bit_cnt == 3'd7);
    assign rx_byte   = {rx_sr, mosi_s};
    assign addr_last = fast ? 3'd3 : 3'd2;

    always_comb begin
        dec_read = (rx_byte == 8'h03);
        dec_fast = 1'b0;
`ifdef SPI_FLASH_SLAVE_FAST_READ_EN
        if (rx_byte == 8'h0B) begin
            dec_read = 1'b1;
            dec_fast = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (cs_s) begin
            state_nx = S_IDLE;
        end else begin
            case (state)
                S_IDLE:   if (cs_fall) state_nx = S_OPCODE;
                S_OPCODE: if (byte_done) begin
                    if (dec_read || rx_byte == 8'h02) state_nx = S_ADDR;
                    else if (rx_byte == 8'h05)        state_nx = S_STATUS;
                    else if (rx_byte == 8'h9F)        state_nx = S_ID;
                    else                              state_nx = S_IGNORE;
                end
                S_ADDR:   if (byte_done && byte_cnt == addr_last)
                    state_nx = is_read ? S_RD_DATA : S_WR_DATA;
                default:  state_nx = state;
            endcase
        end
    end

    // Byte presented on the fall that follows each completed byte.
    always_comb begin
        load_byte = 8'hFF;
        case (state)
            S_STATUS:  load_byte = {6'b0, o_wel, i_busy};
            S_RD_DATA: load_byte = rd_buf;
            S_ID: begin
                case (id_idx)
                    2'd0:    load_byte = JEDEC_ID[23:16];
                    2'd1:    load_byte = JEDEC_ID[15:8];
                    2'd2:    load_byte = JEDEC_ID[7:0];
                    default: load_byte = 8'hFF;
                endcase
            end
            default:   load_byte = 8'hFF;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_spi_miso    <= 1'b1;
            o_mem_addr    <= '0;
            o_mem_rd_req  <= 1'b0;
            o_mem_wr_en   <= 1'b0;
            o_mem_wr_data <= '0;
            o_wel         <= 1'b0;
            o_cmd         <= '0;
            o_cmd_done    <= 1'b0;
            bit_cnt       <= '0;
            byte_cnt      <= '0;
            rx_sr         <= '0;
            tx_sr         <= 8'hFF;
            rd_buf        <= '0;
            rd_pend       <= 1'b0;
            id_idx        <= '0;
            is_read       <= 1'b0;
            fast          <= 1'b0;
            wr_allow      <= 1'b0;
            wrote         <= 1'b0;
            cmd_decoded   <= 1'b0;
        end else begin
            o_mem_rd_req <= 1'b0;
            o_mem_wr_en  <= 1'b0;
            o_cmd_done   <= 1'b0;
            rd_pend      <= o_mem_rd_req;
            if (rd_pend) rd_buf <= i_mem_rd_data;
            // Page wrap: only the low PAGE_BITS advance after a program write.
            if (o_mem_wr_en)
                o_mem_addr[PAGE_BITS-1:0] <= o_mem_addr[PAGE_BITS-1:0] + PAGE_ONE;

            if (cs_rise) begin
                o_cmd_done  <= cmd_decoded;
                cmd_decoded <= 1'b0;
                if (wrote) o_wel <= 1'b0;
                wrote       <= 1'b0;
                o_spi_miso  <= 1'b1;
            end else if (cs_fall) begin
                bit_cnt     <= '0;
                byte_cnt    <= '0;
                id_idx      <= '0;
                cmd_decoded <= 1'b0;
                wrote       <= 1'b0;
                tx_sr       <= 8'hFF;
                o_spi_miso  <= 1'b1;
            end else begin
                if (rise) begin
                    bit_cnt <= bit_cnt + 3'd1;
                    rx_sr   <= rx_byte[6:0];
                    if (bit_cnt == 3'd7 && byte_cnt != 3'd7) byte_cnt <= byte_cnt + 3'd1;
                    case (state)
                        S_OPCODE: if (bit_cnt == 3'd7) begin
                            o_cmd       <= rx_byte;
                            cmd_decoded <= 1'b1;
                            byte_cnt    <= '0;
                            is_read     <= dec_read;
                            fast        <= dec_fast;
                            wr_allow    <= o_wel;
                            if (rx_byte == 8'h06) o_wel <= 1'b1;
                            if (rx_byte == 8'h04) o_wel <= 1'b0;
                        end
                        S_ADDR: begin
                            if (byte_cnt < 3'd3) o_mem_addr <= {o_mem_addr[22:0], mosi_s};
                            if (bit_cnt == 3'd7 && byte_cnt == addr_last && is_read)
                                o_mem_rd_req <= 1'b1;
                        end
                        S_RD_DATA: if (bit_cnt == 3'd7) begin
                            o_mem_addr   <= o_mem_addr + 24'd1;
                            o_mem_rd_req <= 1'b1;
                        end
                        S_WR_DATA: if (bit_cnt == 3'd7 && wr_allow) begin
                            o_mem_wr_en   <= 1'b1;
                            o_mem_wr_data <= rx_byte;
                            wrote         <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                if (fall) begin
                    if (bit_cnt == 3'd0) begin
                        o_spi_miso <= load_byte[7];
                        tx_sr      <= {load_byte[6:0], 1'b1};
                        if (state == S_ID && id_idx != 2'd3) id_idx <= id_idx + 2'd1;
                    end else begin
                        o_spi_miso <= tx_sr[7];
                        tx_sr      <= {tx_sr[6:0], 1'b1};
                    end
                end
            end
        end
    end

endmodule

// File: doc/spi_flash_slave.md
Name: spi_flash_slave

Overview:
- Synthesizable SPI-flash responder: the device end of the flash command link.
- Decodes mode-0 SPI transactions from a flash-command master.
- Serves reads from, and forwards page-program writes to, a byte-wide memory port.
- Used as an on-chip flash model for loopback test and as a field stand-in for the external flash.
- All SPI pins are oversampled in the system clock domain; the slave needs no SPI clock of its own.

Parameters:
- JEDEC_ID, 24'hEF4018: bytes returned MSB-first by opcode 0x9F.
- PAGE_BITS, 8: page-program address wrap width (256-byte page).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- i_spi_cs  in  1  chip select, active low.
- i_spi_dclk  in  1  SPI clock, mode 0.
- i_spi_mosi  in  1  master-out data.
- o_spi_miso  out  1  slave-out data.
- o_mem_addr  out  24  memory byte address.
- o_mem_rd_req  out  1  one-cycle read strobe.
- i_mem_rd_data  in  8  read data, valid the cycle after o_mem_rd_req.
- o_mem_wr_en  out  1  one-cycle write strobe.
- o_mem_wr_data  out  8  write data, qualified by o_mem_wr_en.
- i_busy  in  1  memory busy; reported as status bit 0 (WIP).
- o_wel  out  1  write-enable latch.
- o_cmd  out  8  last decoded opcode.
- o_cmd_done  out  1  one-cycle pulse on cs rising after a decoded opcode.

Behaviour:
- Reset values: o_spi_miso=1; o_wel=0; all other outputs 0.
- Synchronisation and edges:
  - cs, dclk and mosi pass through 2-flop synchronisers, then edge detection.
  - mosi is sampled on each detected dclk rise.
  - miso shifts on each detected dclk fall; MSB first.
  - Requirement on the master: dclk high and low phases each ≥4 clk.
- miso is 1 whenever cs is high or no data is being returned.
- States: IDLE, OPCODE, ADDR, RD_DATA, WR_DATA, STATUS, ID, IGNORE.
- IDLE → OPCODE on cs fall; bit counter cleared.
- OPCODE: after 8 bits, decode:
  - 0x03 → ADDR (read).
  - 0x02 → ADDR (program).
  - 0x05 → STATUS.
  - 0x9F → ID.
  - 0x06 → set WEL, then IGNORE.
  - 0x04 → clear WEL, then IGNORE.
  - Any other opcode → IGNORE.
  - o_cmd is updated at decode.
- ADDR: 24 bits MSB-first into o_mem_addr.
  - Read: on the 24th sampled bit, pulse o_mem_rd_req; capture i_mem_rd_data next cycle into the shift register. Bit 7 drives miso from the following dclk fall.
  - Program: go to WR_DATA.
- RD_DATA:
  - On the rise carrying bit 0 of the current byte, increment o_mem_addr (24-bit wrap FFFFFF→000000) and pulse o_mem_rd_req.
  - The new byte loads at the next fall.
  - Unlimited length.
- WR_DATA: each complete 8-bit byte produces one o_mem_wr_en pulse at the current address.
  - The next address increments the low PAGE_BITS bits only; the upper bits are held (page wrap).
  - If WEL=0 at opcode decode, bytes are shifted in but never written.
- STATUS: repeats {6'b0, WEL, i_busy} every byte; i_busy is sampled at each byte load.
- ID: returns JEDEC_ID bytes MSB-first, then 0xFF thereafter.
- cs rise in any state:
  - Return to IDLE; discard any partial byte.
  - Pulse o_cmd_done if the opcode completed.
  - Clear WEL if the opcode was 0x02 and at least one byte was written.
- Reset asserted mid-transaction: immediate return to reset values. The transaction resumes only at the next cs fall.
- Simultaneous cs rise and dclk edge: cs wins; the edge is ignored.

Optional Feature:
- Macro: SPI_FLASH_SLAVE_FAST_READ_EN.
- Defined: opcode 0x0B is accepted as fast read.
  - After the 24 address bits, 8 dummy clocks are counted with miso=1.
  - o_mem_rd_req is pulsed on the 8th dummy rise; first data is driven at the following fall.
  - Otherwise identical to 0x03.
- Undefined: 0x0B → IGNORE, miso=1, no memory access.

Test Plan:
- Status: 0x06 then 0x05 with i_busy=0 → miso 0x02. o_cmd=0x05 with a o_cmd_done pulse; o_wel=1.
- Read: 0x03, addr 0x112233, 4 bytes, model returns addr[7:0]+0x10.
  - o_mem_rd_req at 0x112233..0x112236.
  - miso 0x43,0x44,0x45,0x46.
- Program with wrap: 0x06, then 0x02 addr 0x0000FE, data 0x35,0x36,0x37.
  - Writes 0x35@0x0000FE, 0x36@0x0000FF, 0x37@0x000000.
  - o_wel=0 after cs rise.
- Program without WREN: 0x02 addr 0x000010, data 0xAA → no o_mem_wr_en pulse; o_cmd_done pulses.
- ID: 0x9F, 4 bytes → 0xEF,0x40,0x18,0xFF.
- Abort: cs rises after 5 opcode bits, then a normal 0x03 read at 0x000000 → no o_cmd_done for the aborted transfer; correct data on the retry.
